truth_table_sweeper: RTL
========================

Name: truth_table_sweeper

Overview:
- Sequential stimulus/response engine for the team's 4-input/10-output combinational function boards.
- Drives every input code 0..2^NUM_IN-1 onto the board in turn. After a programmable settle time it reads back the board's output vector and compares it, under a mask, against an expected row.
- Reports a mismatch count, the first failing row, a pass flag and a 16-bit rotating response signature.
- Replaces the hand-delayed testbench sweep with a synthesizable on-chip checker.

Parameters:
- NUM_IN, 4, number of board inputs. Rows = 2^NUM_IN; stim bit NUM_IN-1 is the high input (w), bit 0 the low input (z).
- NUM_OUT, 10, width of the board response vector (f0 = bit 0). Must be ≤ 16.
- SETTLE_CYCLES, 4, clock cycles per row between stim update and sampling. Must be ≥ 1.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle request to begin a sweep.
- abort, input, 1, synchronous sweep cancel.
- stim, output, NUM_IN, input code driven to the board; also the current row index.
- resp, input, NUM_OUT, board outputs, sampled.
- exp, input, NUM_OUT, expected outputs for row stim; combinational from stim, externally.
- mask, input, NUM_OUT, 1 = compare/signature bit, 0 = don't-care.
- busy, output, 1, sweep in progress.
- done, output, 1, sweep complete; results valid.
- pass, output, 1, done with err_count == 0.
- err_count, output, NUM_IN+1, number of mismatching rows.
- fail_valid, output, 1, at least one row has mismatched.
- first_fail, output, NUM_IN, row index of the first mismatch.
- sig, output, 16, response signature.

Behaviour:
- Async reset (rst_n low): all outputs 0 (stim, busy, done, pass, err_count, fail_valid, first_fail, sig); FSM = IDLE; settle counter = 0. Reset mid-sweep discards the sweep; no partial results are kept.
- FSM states: IDLE, SETTLE, DONE.
- IDLE or DONE, start=1, abort=0: at that edge stim←0, err_count←0, fail_valid←0, first_fail←0, sig←0, done←0, pass←0, busy←1, cnt←0; go to SETTLE.
- SETTLE: cnt increments each edge. At the edge where cnt == SETTLE_CYCLES-1 (the sample edge):
  - m = (resp ^ exp) & mask.
  - sig ← {sig[14:0], sig[15]} ^ zero-extend(resp & mask).
  - If m ≠ 0: err_count += 1. If fail_valid was 0, also fail_valid←1 and first_fail←stim.
  - If stim == 2^NUM_IN-1: busy←0, done←1, pass←(updated err_count == 0), go to DONE. stim holds its last value.
  - Otherwise: stim←stim+1, cnt←0, stay in SETTLE.
- Row timing: each row lasts exactly SETTLE_CYCLES cycles. resp is sampled SETTLE_CYCLES edges after stim changed.
- Sweep timing: done rises at edge 2^NUM_IN × SETTLE_CYCLES, counted from the start edge (edge 0). Default: 64.
- DONE: all results are held until the next accepted start or reset.
- start while in SETTLE: ignored.
- start and abort in the same cycle: abort wins.
- abort (any state): at that edge → IDLE; busy←0, done←0, pass←0, stim←0. err_count, fail_valid, first_fail and sig keep their current values for debug.
- err_count cannot overflow: max 2^NUM_IN fits in NUM_IN+1 bits.
- mask bits are ANDed into both the comparison and the signature.

Test Plan:
- Matching board, defaults: resp = exp for all rows, mask = 10'h3FF, one start pulse → busy high for 64 cycles, done at edge 64, pass=1, err_count=0, fail_valid=0.
- Signature: resp = exp = 10'h001 for all rows, mask = 10'h3FF → sig = 16'hFFFF at done. resp = exp = 0 → sig = 16'h0000.
- Single fault: resp bit 7 flipped only on rows 9 and 12 → err_count=2, fail_valid=1, first_fail=9, pass=0. Same fault with mask bit 7 = 0 → pass=1, err_count=0.
- Control: abort asserted at cycle 30 → busy=0, done=0, stim=0 next cycle. start held during SETTLE has no effect on timing. start after done clears results and re-sweeps in 64 cycles.
- Reset: rst_n low at cycle 40 (asynchronous, mid-clock) → all outputs 0 immediately. A fresh start after release completes normally.
- SETTLE_CYCLES=1: done at edge 16. resp is sampled the edge after each stim change; resp delayed by 2 cycles relative to stim yields mismatches.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks every input code of a small combinational board,
// waits a programmable settle time per row, then compares the masked board
// response against the expected row. It accumulates a mismatch count, the
// first failing row, a pass flag and a rotating response signature.
//
// Handshake: start is a one-cycle request that is accepted only in IDLE or
// DONE. abort is honoured in every state and takes priority over start.
// busy is high from the accepting edge until the last row is sampled. done
// then rises and the results stay valid until the next accepted start, abort
// or reset.
module truth_table_sweeper #(
    parameter int NUM_IN        = 4,
    parameter int NUM_OUT       = 10,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic [NUM_IN-1:0]  stim,
    input  logic [NUM_OUT-1:0] resp,
    input  logic [NUM_OUT-1:0] exp,
    input  logic [NUM_OUT-1:0] mask,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NUM_IN:0]    err_count,
    output logic               fail_valid,
    output logic [NUM_IN-1:0]  first_fail,
    output logic [15:0]        sig,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int                 CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [NUM_IN-1:0]  ROW_LAST = '1;
    localparam logic [NUM_IN-1:0]  ROW_ONE  = NUM_IN'(1);
    localparam logic [NUM_IN:0]    ERR_ONE  = (NUM_IN + 1)'(1);

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [NUM_IN-1:0]   r_stim, w_stim_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_pass, w_pass_nxt;
    logic [NUM_IN:0]     r_err, w_err_nxt;
    logic                r_fail_valid, w_fail_valid_nxt;
    logic [NUM_IN-1:0]   r_first_fail, w_first_fail_nxt;
    logic [15:0]         r_sig, w_sig_nxt;

    logic                w_mis;
    logic [NUM_IN:0]     w_err_upd;
    logic [15:0]         w_resp_ext;

    // Masked compare of the current row and the masked response widened for the signature
    always_comb begin
        w_mis      = |((resp ^ exp) & mask);
        w_err_upd  = w_mis ? (r_err + ERR_ONE) : r_err;
        w_resp_ext = '0;
        w_resp_ext[NUM_OUT-1:0] = resp & mask;
    end

    // Next-state and result-update logic; abort overrides everything else
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_stim_nxt       = r_stim;
        w_busy_nxt       = r_busy;
        w_done_nxt       = r_done;
        w_pass_nxt       = r_pass;
        w_err_nxt        = r_err;
        w_fail_valid_nxt = r_fail_valid;
        w_first_fail_nxt = r_first_fail;
        w_sig_nxt        = r_sig;

        if (abort) begin
            // Error history is kept for debug; only the sweep control is cleared
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
            w_pass_nxt  = 1'b0;
            w_stim_nxt  = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        w_state_nxt      = SETTLE;
                        w_stim_nxt       = '0;
                        w_err_nxt        = '0;
                        w_fail_valid_nxt = 1'b0;
                        w_first_fail_nxt = '0;
                        w_sig_nxt        = '0;
                        w_done_nxt       = 1'b0;
                        w_pass_nxt       = 1'b0;
                        w_busy_nxt       = 1'b1;
                        w_cnt_nxt        = '0;
                    end
                end
                SETTLE: begin
                    if (r_cnt == CNT_LAST) begin
                        // Sample edge: resp has had SETTLE_CYCLES edges to follow stim
                        w_sig_nxt = {r_sig[14:0], r_sig[15]} ^ w_resp_ext;
                        w_err_nxt = w_err_upd;
                        if (w_mis && !r_fail_valid) begin
                            w_fail_valid_nxt = 1'b1;
                            w_first_fail_nxt = r_stim;
                        end
                        if (r_stim == ROW_LAST) begin
                            // Last row: stim holds its final code while in DONE
                            w_state_nxt = DONE;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                            w_pass_nxt  = (w_err_upd == '0);
                        end else begin
                            w_stim_nxt = r_stim + ROW_ONE;
                            w_cnt_nxt  = '0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State and result registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_stim       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_first_fail <= '0;
            r_sig        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_stim       <= w_stim_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_pass       <= w_pass_nxt;
            r_err        <= w_err_nxt;
            r_fail_valid <= w_fail_valid_nxt;
            r_first_fail <= w_first_fail_nxt;
            r_sig        <= w_sig_nxt;
        end
    end

    assign stim       = r_stim;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign fail_valid = r_fail_valid;
    assign first_fail = r_first_fail;
    assign sig        = r_sig;
    assign dbg_state  = r_state;

endmodule
